sysid_reader_master: RTL and testbench

SYSID_READER_MASTER -- requirements
Module: sysid_reader_master

---
 rtl/sysid_reader_master.sv | 97 +++++++++
 tb/tb_sysid_reader_master.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sysid_reader_master.sv
// rtl/sysid_reader_master.sv - reads system-ID and timestamp words over Avalon-MM and compares them
// Two-read check sequence with a per-state stall/response timeout.
module sysid_reader_master #(
   parameter logic [31:0] EXPECTED_ID        = 32'd0,
   parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1520871514,
   parameter int          TIMEOUT_CYCLES     = 255
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   output logic        avm_address,
   output logic        avm_read,
   input  logic        avm_waitrequest,
   input  logic [31:0] avm_readdata,
   input  logic        avm_readdatavalid,
   output logic        busy,
   output logic        done,
   output logic [31:0] id_value,
   output logic [31:0] timestamp_value,
   output logic        match,
   output logic        timeout
);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_ID_REQ  = 3'd1;
   localparam logic [2:0] S_ID_WAIT = 3'd2;
   localparam logic [2:0] S_TS_REQ  = 3'd3;
   localparam logic [2:0] S_TS_WAIT = 3'd4;
   localparam logic [2:0] S_FINISH  = 3'd5;

   localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES - 1);

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [15:0] tcnt;
   logic        in_bus;
   logic        expire;

   always_comb begin
      state_nxt = state;
      case (state)
         S_IDLE:    if (start)              state_nxt = S_ID_REQ;
         S_ID_REQ:  if (!avm_waitrequest)   state_nxt = S_ID_WAIT;
         S_ID_WAIT: if (avm_readdatavalid)  state_nxt = S_TS_REQ;
         S_TS_REQ:  if (!avm_waitrequest)   state_nxt = S_TS_WAIT;
         S_TS_WAIT: if (avm_readdatavalid)  state_nxt = S_FINISH;
         default:                           state_nxt = S_IDLE;
      endcase
   end

   assign in_bus      = (state == S_ID_REQ) || (state == S_ID_WAIT) ||
                        (state == S_TS_REQ) || (state == S_TS_WAIT);
   // A pending transition always beats the timeout in the same cycle.
   assign expire      = in_bus && (state_nxt == state) && (tcnt == TIMEOUT_LIMIT);
   assign avm_read    = (state == S_ID_REQ) || (state == S_TS_REQ);
   assign avm_address = (state == S_TS_REQ);
   assign busy        = (state != S_IDLE);

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state           <= S_IDLE;
         tcnt            <= 16'd0;
         done            <= 1'b0;
         id_value        <= 32'd0;
         timestamp_value <= 32'd0;
         match           <= 1'b0;
         timeout         <= 1'b0;
      end else begin
         done <= 1'b0;
         if (expire) begin
            state   <= S_IDLE;
            tcnt    <= 16'd0;
            done    <= 1'b1;
            timeout <= 1'b1;
            match   <= 1'b0;
         end else begin
            state <= state_nxt;
            if (state_nxt != state)
               tcnt <= 16'd0;
            else if (in_bus)
               tcnt <= tcnt + 16'd1;

            if (state == S_ID_WAIT && avm_readdatavalid)
               id_value <= avm_readdata;

            // The timestamp and the match verdict land together as FINISH is entered.
            if (state == S_TS_WAIT && avm_readdatavalid) begin
               timestamp_value <= avm_readdata;
               match   <= (id_value == EXPECTED_ID) && (avm_readdata == EXPECTED_TIMESTAMP);
               timeout <= 1'b0;
               done    <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_sysid_reader_master.sv
// tb/tb_sysid_reader_master.sv - scoreboard bench for sysid_reader_master
module tb_sysid_reader_master;

   localparam logic [31:0] TS = 32'd1520871514;

   logic        clock = 1'b0;
   logic        reset;
   logic        start;
   logic        avm_address;
   logic        avm_read;
   logic        avm_waitrequest;
   logic [31:0] avm_readdata;
   logic        avm_readdatavalid;
   logic        busy;
   logic        done;
   logic [31:0] id_value;
   logic [31:0] timestamp_value;
   logic        match;
   logic        timeout;

   sysid_reader_master #(.TIMEOUT_CYCLES(8)) dut (
      .clock(clock), .reset(reset), .start(start),
      .avm_address(avm_address), .avm_read(avm_read),
      .avm_waitrequest(avm_waitrequest), .avm_readdata(avm_readdata),
      .avm_readdatavalid(avm_readdatavalid), .busy(busy), .done(done),
      .id_value(id_value), .timestamp_value(timestamp_value),
      .match(match), .timeout(timeout)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic [31:0] id;
      logic [31:0] ts;
      logic        m;
      logic        t;
   } exp_t;

   exp_t        q[$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          done_count = 0;
   int          done_cyc = 0;
   int          start_cyc = 0;
   int          accepts = 0;
   int          wait_cycles = 0;
   int          rdv_delay = 0;
   logic        stuck = 1'b0;
   logic        early_junk = 1'b0;
   logic [31:0] id_data = 32'd0;
   logic [31:0] ts_data = TS;
   logic [31:0] junk = 32'h1234_5678;

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, got, exp);
      end
   endtask

   task automatic cycle_counter();
      forever begin
         @(posedge clock);
         cyc++;
      end
   endtask

   task automatic slave();
      int   stall = 0;
      int   pend = 0;
      logic paddr = 1'b0;
      forever begin
         @(posedge clock);
         #1;
         avm_readdatavalid = 1'b0;
         avm_readdata      = 32'd0;
         if (pend > 0) begin
            pend--;
            if (pend == 0) begin
               avm_readdatavalid = 1'b1;
               avm_readdata      = paddr ? ts_data : id_data;
            end
         end
         if (stuck)
            avm_waitrequest = 1'b1;
         else if (avm_read && stall < wait_cycles) begin
            avm_waitrequest = 1'b1;
            stall++;
         end else
            avm_waitrequest = 1'b0;
         if (early_junk && avm_read && !avm_waitrequest && !avm_readdatavalid) begin
            avm_readdatavalid = 1'b1;
            avm_readdata      = junk;
         end
         @(negedge clock);
         if (avm_read && !avm_waitrequest) begin
            pend  = 1 + rdv_delay;
            paddr = avm_address;
            stall = 0;
            accepts++;
         end
      end
   endtask

   task automatic monitor();
      logic prev_stall = 1'b0;
      logic prev_addr  = 1'b0;
      exp_t e;
      forever begin
         @(negedge clock);
         if (!reset && prev_stall && !stuck) begin
            chk("stall_read", {31'd0, avm_read}, 32'd1);
            chk("stall_addr", {31'd0, avm_address}, {31'd0, prev_addr});
         end
         prev_stall = avm_read && avm_waitrequest;
         prev_addr  = avm_address;
         if (done) begin
            done_count++;
            done_cyc = cyc;
            if (q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_done: got done=1 expected none at cycle %0d", cyc);
            end else begin
               e = q.pop_front();
               chk("id_value", id_value, e.id);
               chk("timestamp_value", timestamp_value, e.ts);
               chk("match", {31'd0, match}, {31'd0, e.m});
               chk("timeout", {31'd0, timeout}, {31'd0, e.t});
            end
         end
      end
   endtask

   task automatic pulse_start();
      @(posedge clock);
      #1;
      start     = 1'b1;
      start_cyc = cyc;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic wait_dones(input int target);
      for (int i = 0; i < 60 && done_count < target; i++)
         @(posedge clock);
      #2;
      if (done_count < target)
         chk("done_wait", done_count, target);
   endtask

   task automatic wait_accept(input logic addr);
      int i;
      for (i = 0; i < 40; i++) begin
         @(negedge clock);
         if (avm_read && !avm_waitrequest && avm_address == addr)
            break;
      end
      if (i == 40)
         chk("accept_wait", 32'd0, 32'd1);
   endtask

   initial begin
      int acc0;
      int dc0;
      reset = 1'b1;
      start = 1'b0;
      avm_waitrequest   = 1'b0;
      avm_readdata      = 32'd0;
      avm_readdatavalid = 1'b0;
      fork
         cycle_counter();
         slave();
         monitor();
      join_none

      repeat (2) @(negedge clock);
      chk("rst_busy", {31'd0, busy}, 32'd0);
      chk("rst_done", {31'd0, done}, 32'd0);
      chk("rst_read", {31'd0, avm_read}, 32'd0);
      chk("rst_addr", {31'd0, avm_address}, 32'd0);
      chk("rst_match", {31'd0, match}, 32'd0);
      chk("rst_timeout", {31'd0, timeout}, 32'd0);
      chk("rst_id", id_value, 32'd0);
      chk("rst_ts", timestamp_value, 32'd0);
      reset = 1'b0;

      // Zero-wait slave: done in the 6th cycle counting the start cycle as 1.
      acc0 = accepts;
      q.push_back('{id: 32'd0, ts: TS, m: 1'b1, t: 1'b0});
      pulse_start();
      wait_dones(1);
      chk("latency", done_cyc - start_cyc, 32'd5);
      chk("reads_zero_wait", accepts - acc0, 32'd2);

      // Three stall cycles per read.
      wait_cycles = 3;
      acc0 = accepts;
      q.push_back('{id: 32'd0, ts: TS, m: 1'b1, t: 1'b0});
      pulse_start();
      wait_dones(2);
      chk("reads_stall", accepts - acc0, 32'd2);
      wait_cycles = 0;

      // Timestamp off by one.
      ts_data = TS + 32'd1;
      q.push_back('{id: 32'd0, ts: TS + 32'd1, m: 1'b0, t: 1'b0});
      pulse_start();
      wait_dones(3);

      // Response in the acceptance cycle must be dropped.
      ts_data    = TS;
      early_junk = 1'b1;
      q.push_back('{id: 32'd0, ts: TS, m: 1'b1, t: 1'b0});
      pulse_start();
      wait_dones(4);
      early_junk = 1'b0;

      // Wrong ID.
      id_data = 32'd5;
      q.push_back('{id: 32'd5, ts: TS, m: 1'b0, t: 1'b0});
      pulse_start();
      wait_dones(5);

      // Waitrequest stuck: abort 8 cycles after entering ID_REQ, captures untouched.
      stuck = 1'b1;
      q.push_back('{id: 32'd5, ts: TS, m: 1'b0, t: 1'b1});
      pulse_start();
      wait_dones(6);
      chk("timeout_latency", done_cyc - start_cyc, 32'd9);
      repeat (2) @(negedge clock);
      chk("timeout_read_low", {31'd0, avm_read}, 32'd0);
      chk("timeout_idle", {31'd0, busy}, 32'd0);
      stuck   = 1'b0;
      id_data = 32'd0;
      repeat (2) @(posedge clock);

      // Start pulsed during ID_WAIT is ignored.
      q.push_back('{id: 32'd0, ts: TS, m: 1'b1, t: 1'b0});
      dc0 = done_count;
      pulse_start();
      wait_accept(1'b0);
      @(posedge clock);
      #1;
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
      wait_dones(dc0 + 1);
      repeat (12) @(posedge clock);
      chk("single_done", done_count - dc0, 32'd1);

      // Reset during TS_WAIT with a response arriving after release.
      id_data   = 32'd7;
      rdv_delay = 3;
      dc0 = done_count;
      pulse_start();
      wait_accept(1'b1);
      @(posedge clock);
      #1;
      chk("pre_reset_id", id_value, 32'd7);
      reset = 1'b1;
      #2;
      chk("mid_rst_busy", {31'd0, busy}, 32'd0);
      chk("mid_rst_read", {31'd0, avm_read}, 32'd0);
      chk("mid_rst_id", id_value, 32'd0);
      chk("mid_rst_match", {31'd0, match}, 32'd0);
      chk("mid_rst_done", {31'd0, done}, 32'd0);
      @(negedge clock);
      reset = 1'b0;
      repeat (8) @(posedge clock);
      #2;
      chk("no_done_after_reset", done_count - dc0, 32'd0);
      chk("late_rdv_id", id_value, 32'd0);
      chk("late_rdv_ts", timestamp_value, 32'd0);
      chk("late_rdv_busy", {31'd0, busy}, 32'd0);
      chk("late_rdv_match", {31'd0, match}, 32'd0);
      chk("late_rdv_timeout", {31'd0, timeout}, 32'd0);
      chk("scoreboard_empty", q.size(), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got no finish expected finish before 200000");
      $fatal(1);
   end

endmodule
